man_div_seq: RTL
================

MAN_DIV_SEQ -- requirements
Module: man_div_seq

Interface
REQ-001 SHALL have parameter SIZE_DATA, default 24, giving the mantissa width including the hidden bit.
REQ-002 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port i_start  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port i_data_a  input  SIZE_DATA  dividend mantissa, normalized (MSB=1).
REQ-006 SHALL have port i_data_b  input  SIZE_DATA  divisor mantissa, normalized (MSB=1) or zero.
REQ-007 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port o_valid  output  1  single-cycle result strobe.
REQ-009 SHALL have port o_data_div  output  SIZE_DATA  normalized quotient mantissa.
REQ-010 SHALL have port o_under_flag  output  1  quotient <1.0, exponent must be decremented by 1.
REQ-011 SHALL have port o_rounding  output  1  round-up request.
REQ-012 SHALL have port o_div_zero  output  1  divisor was zero.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, DONE; IDLE->CALC on i_start, CALC->DONE after the last iteration, DONE->IDLE unconditionally.
REQ-014 SHALL capture i_data_a and i_data_b on the i_start edge; input changes afterwards have no effect.
REQ-015 SHALL ignore i_start in CALC and DONE; there is no queueing.
REQ-016 SHALL compute Q = floor(A*2^(SIZE_DATA+2)/B), a (SIZE_DATA+3)-bit quotient, by restoring division at one bit per cycle, MSB first: q=(R>=B); R=(q ? R-B : R)<<1; R starts at A; R is SIZE_DATA+1 bits wide.
REQ-017 SHALL run exactly SIZE_DATA+3 (27) CALC iterations via an iteration counter.
REQ-018 SHALL assert o_valid for exactly one cycle, in DONE, following the edge 27 cycles after the start edge.
REQ-019 SHALL, if Q[26]=1: o_under_flag=0, o_data_div=Q[26:3], G=Q[2], R=Q[1], S=Q[0] | (final remainder != 0).
REQ-020 SHALL, if Q[26]=0: o_under_flag=1, o_data_div=Q[25:2], G=Q[1], R=Q[0], S=(final remainder != 0).
REQ-021 SHALL drive o_rounding = (G&R) | (R&S), the same rule as the mantissa multiplier.
REQ-022 SHALL register all outputs; o_data_div, o_under_flag, o_rounding and o_div_zero hold until the next o_valid.
REQ-023 SHALL accept a new i_start in the first IDLE cycle after DONE, giving a back-to-back period of 29 cycles.

Reset
REQ-024 SHALL, on i_rst_n low, immediately force state IDLE and counter 0, and drive all outputs to 0.
REQ-025 SHALL abandon an in-flight division on reset mid-CALC and emit no o_valid for it after release.
REQ-026 SHALL accept i_start on the first rising edge after i_rst_n deasserts.

Configuration
REQ-027 SHALL provide macro MAN_DIV_DBZ_CHECK_EN.
- Defined: i_data_b==0 at start goes IDLE->DONE in one edge (o_valid 1 cycle later), with o_data_div all ones, o_div_zero=1, o_under_flag=0, o_rounding=0.
- Undefined: o_div_zero is tied 0 and a zero divisor runs the normal 27-cycle path, giving o_data_div all ones, o_under_flag=0, o_rounding=1.

Verification
REQ-028 SHALL cover 1.0/1.0: A=B=0x800000 -> after 27 cycles o_data_div=0x800000, o_under_flag=0, o_rounding=0.
REQ-029 SHALL cover 1.0/1.5: A=0x800000, B=0xC00000 -> o_data_div=0xAAAAAA, o_under_flag=1, G=1 R=0 S=1, o_rounding=0.
REQ-030 SHALL cover max/1.0: A=0xFFFFFF, B=0x800000 -> o_data_div=0xFFFFFF, o_under_flag=0, o_rounding=0.
REQ-031 SHALL cover start while busy: i_start pulsed at cycles 5 and 20 after the first start -> exactly one o_valid, result of the first operands.
REQ-032 SHALL cover reset mid-CALC: i_rst_n low at iteration 10 -> outputs 0 immediately, no o_valid; a new start afterwards completes correctly in 27 cycles.
REQ-033 SHALL cover zero divisor: B=0, with MAN_DIV_DBZ_CHECK_EN -> o_valid 1 cycle after start with o_div_zero=1; without the macro -> o_valid at 27 cycles with o_data_div=0xFFFFFF, o_rounding=1.

Source files
------------

// File: rtl/man_div_seq.sv
// rtl/man_div_seq.sv - sequential restoring divider for normalized mantissas, one quotient bit per cycle.
// Optional zero-divisor short-cut enabled by defining MAN_DIV_DBZ_CHECK_EN.
module man_div_seq #(
   parameter int SIZE_DATA = 24
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_start,
   input  logic [SIZE_DATA-1:0] i_data_a,
   input  logic [SIZE_DATA-1:0] i_data_b,
   output logic                 o_busy,
   output logic                 o_valid,
   output logic [SIZE_DATA-1:0] o_data_div,
   output logic                 o_under_flag,
   output logic                 o_rounding,
   output logic                 o_div_zero
);

   localparam int QW = SIZE_DATA + 3;
   localparam int RW = SIZE_DATA + 1;
   localparam int CW = $clog2(QW + 1);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [RW-1:0]        rem_q, rem_d;
   logic [SIZE_DATA-1:0] div_q, div_d;
   logic [QW-1:0]        quo_q, quo_d;
   logic                 busy_q, busy_d;
   logic                 valid_q, valid_d;
   logic [SIZE_DATA-1:0] data_q, data_d;
   logic                 uf_q, uf_d;
   logic                 rnd_q, rnd_d;
   logic                 dz_q, dz_d;

   logic                 q_bit;
   logic [RW-1:0]        rem_sub;
   logic [RW-1:0]        rem_nx;
   logic [QW-1:0]        quo_nx;
   logic                 g_bit, r_bit, s_bit;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         div_q   <= '0;
         quo_q   <= '0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         data_q  <= '0;
         uf_q    <= 1'b0;
         rnd_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         div_q   <= div_d;
         quo_q   <= quo_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         uf_q    <= uf_d;
         rnd_q   <= rnd_d;
         dz_q    <= dz_d;
      end
   end

   // One restoring step: compare, conditionally subtract, shift left.
   always_comb begin
      q_bit   = (rem_q >= {1'b0, div_q});
      rem_sub = q_bit ? (rem_q - {1'b0, div_q}) : rem_q;
      rem_nx  = {rem_sub[RW-2:0], 1'b0};
      quo_nx  = {quo_q[QW-2:0], q_bit};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      div_d   = div_q;
      quo_d   = quo_q;
      valid_d = 1'b0;
      data_d  = data_q;
      uf_d    = uf_q;
      rnd_d   = rnd_q;
      dz_d    = dz_q;
      g_bit   = 1'b0;
      r_bit   = 1'b0;
      s_bit   = 1'b0;

      case (state_q)
         IDLE: begin
            if (i_start) begin
               rem_d   = {1'b0, i_data_a};
               div_d   = i_data_b;
               quo_d   = '0;
               cnt_d   = '0;
`ifdef MAN_DIV_DBZ_CHECK_EN
               if (i_data_b == '0) begin
                  state_d = DONE;
                  valid_d = 1'b1;
                  data_d  = '1;
                  uf_d    = 1'b0;
                  rnd_d   = 1'b0;
                  dz_d    = 1'b1;
               end else begin
                  state_d = CALC;
               end
`else
               state_d = CALC;
`endif
            end
         end

         CALC: begin
            rem_d = rem_nx;
            quo_d = quo_nx;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(QW - 1)) begin
               state_d = DONE;
               valid_d = 1'b1;
               dz_d    = 1'b0;
               // Quotient below 1.0 shifts one extra bit into the mantissa.
               if (quo_nx[QW-1]) begin
                  uf_d   = 1'b0;
                  data_d = quo_nx[QW-1:3];
                  g_bit  = quo_nx[2];
                  r_bit  = quo_nx[1];
                  s_bit  = quo_nx[0] | (rem_nx != '0);
               end else begin
                  uf_d   = 1'b1;
                  data_d = quo_nx[QW-2:2];
                  g_bit  = quo_nx[1];
                  r_bit  = quo_nx[0];
                  s_bit  = (rem_nx != '0);
               end
               rnd_d = (g_bit & r_bit) | (r_bit & s_bit);
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign o_busy       = busy_q;
   assign o_valid      = valid_q;
   assign o_data_div   = data_q;
   assign o_under_flag = uf_q;
   assign o_rounding   = rnd_q;
   assign o_div_zero   = dz_q;

endmodule
